// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types, memory-stage control and data-memory FSM states
package riscv_pkg;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} mem_op_t;

    typedef struct packed {
        logic    mem_en;
        mem_op_t wr;
    } MEM_ctrl;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} dmem_state_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
endpackage

// File: rtl/dmem_if_if.sv
// dmem_if_if: request/grant/valid bus between the MEM stage and data memory
interface dmem_if_if #(parameter int AW = 32, parameter int DW = 32);
    logic          proc_req;
    logic          proc_we;
    logic [AW-1:0] proc_addr;
    logic [3:0]    proc_be;
    logic [DW-1:0] proc_wdata;
    logic          proc_gnt;
    logic          proc_valid;
    logic [DW-1:0] proc_rdata;

    modport master (output proc_req, proc_we, proc_addr, proc_be, proc_wdata,
                    input  proc_gnt, proc_valid, proc_rdata);
    modport slave  (input  proc_req, proc_we, proc_addr, proc_be, proc_wdata,
                    output proc_gnt, proc_valid, proc_rdata);
endinterface

// File: rtl/dmem_align.sv
// dmem_align: store lane replication / byte enables, load extraction / extension, access legality
module dmem_align
    import riscv_pkg::*;
(
    input  logic [2:0]  st_f3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    input  logic [2:0]  ld_f3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o,
    output logic        bad_o
);
    logic [7:0]  b;
    logic [15:0] h;

    // store side works on the live instruction fields
    assign be_o    = st_f3_i[1:0] == 2'b00 ? 4'b0001 << st_off_i :
                     st_f3_i[1:0] == 2'b01 ? (st_off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_o = st_f3_i[1:0] == 2'b00 ? {4{st_data_i[7:0]}} :
                     st_f3_i[1:0] == 2'b01 ? {2{st_data_i[15:0]}} : st_data_i;
    assign bad_o   = st_f3_i == 3'b011 || st_f3_i[2:1] == 2'b11 ||
                     (st_f3_i[1:0] == 2'b01 && st_off_i[0]) ||
                     (st_f3_i == LSU_W && st_off_i != 2'b00);

    // load side uses the offset and funct3 latched at request time
    assign b = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    assign h = ld_off_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    assign ld_data_o = ld_f3_i == LSU_B  ? {{24{b[7]}}, b} :
                       ld_f3_i == LSU_BU ? {24'b0, b} :
                       ld_f3_i == LSU_H  ? {{16{h[15]}}, h} :
                       ld_f3_i == LSU_HU ? {16'b0, h} : ld_rdata_i;
endmodule

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage data-memory handshake FSM with registered request fields and load result
module dmem_if
    import riscv_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          EN,
    input  logic          HZ_data_req,
    input  MEM_ctrl       MEMctrl_in,
    input  logic [2:0]    FUNCT3_in,
    input  logic [AW-1:0] ADDR_in,
    input  logic [DW-1:0] WDATA_in,
    output logic          DATA_mem_busy_out,
    output logic [DW-1:0] RDATA_out,
    output logic          ERR_out,
    dmem_if_if.master     bus
);
    dmem_state_t   state_q;
    logic          req_q, we_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, ld_d;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic          bad, ask, start;

    dmem_align u_align (
        .st_f3_i   (FUNCT3_in),
        .st_off_i  (ADDR_in[1:0]),
        .st_data_i (WDATA_in),
        .ld_f3_i   (f3_q),
        .ld_off_i  (off_q),
        .ld_rdata_i(bus.proc_rdata),
        .be_o      (be_d),
        .wdata_o   (wdata_d),
        .ld_data_o (ld_d),
        .bad_o     (bad)
    );

    assign ask               = EN && HZ_data_req && MEMctrl_in.mem_en && state_q == IDLE;
    assign start             = ask && !bad;
    assign ERR_out           = ask && bad;
    assign DATA_mem_busy_out = start || state_q == REQ || state_q == WAIT_R;
    assign RDATA_out         = rdata_q;
    assign bus.proc_req      = req_q;
    assign bus.proc_we       = we_q;
    assign bus.proc_addr     = addr_q;
    assign bus.proc_be       = be_q;
    assign bus.proc_wdata    = wdata_q;

    // access FSM: latch on start, hold request until grant, capture aligned load data on valid
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    we_q    <= MEMctrl_in.wr == WRITE;
                    addr_q  <= {ADDR_in[AW-1:2], 2'b00};
                    be_q    <= be_d;
                    wdata_q <= wdata_d;
                    off_q   <= ADDR_in[1:0];
                    f3_q    <= FUNCT3_in;
                end
                REQ: if (bus.proc_gnt) begin
                    req_q   <= 1'b0;
                    state_q <= we_q ? DONE : WAIT_R;
                end
                WAIT_R: if (bus.proc_valid) begin
                    rdata_q <= ld_d;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_if.sv
// tb_dmem_if: directed-vector bench for the data-memory interface
module tb_dmem_if;
    import riscv_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        EN = 1'b0;
    logic        HZ_data_req = 1'b0;
    MEM_ctrl     ctl = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, err;
    logic [31:0] rdata;
    int          errors = 0;
    int          checks = 0;

    dmem_if_if #(.AW(32), .DW(32)) bus ();

    dmem_if #(.AW(32), .DW(32)) dut (
        .CLK              (CLK),
        .RSTn             (RSTn),
        .EN               (EN),
        .HZ_data_req      (HZ_data_req),
        .MEMctrl_in       (ctl),
        .FUNCT3_in        (f3),
        .ADDR_in          (addr),
        .WDATA_in         (wdata),
        .DATA_mem_busy_out(busy),
        .RDATA_out        (rdata),
        .ERR_out          (err),
        .bus              (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic present(input mem_op_t wr, input logic [2:0] fn, input logic [31:0] a,
                           input logic [31:0] wd, input logic hz);
        EN = 1'b1;
        HZ_data_req = hz;
        ctl.mem_en = 1'b1;
        ctl.wr = wr;
        f3 = fn;
        addr = a;
        wdata = wd;
    endtask

    task automatic idle_step();
        @(negedge CLK);
        ctl.mem_en = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_req", bus.proc_req, 0);
    endtask

    // gd = grant wait cycles in REQ, vd = extra WAIT_R cycles before valid; ends in DONE
    task automatic access(input mem_op_t wr, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] wd, input int gd, input int vd,
                          input logic [31:0] rd, input logic [31:0] ea, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        @(negedge CLK);
        present(wr, fn, a, wd, 1'b1);
        bus.proc_gnt = 1'b0;
        bus.proc_valid = 1'b0;
        #1;
        chk("start_busy", busy, 1);
        chk("start_err", err, 0);
        repeat (gd) begin
            @(negedge CLK);
            #1;
            chk("stall_req", bus.proc_req, 1);
            chk("stall_addr", bus.proc_addr, ea);
            chk("stall_busy", busy, 1);
        end
        @(negedge CLK);
        bus.proc_gnt = 1'b1;
        #1;
        chk("req", bus.proc_req, 1);
        chk("addr", bus.proc_addr, ea);
        chk("we", bus.proc_we, wr == WRITE);
        chk("req_busy", busy, 1);
        if (wr == WRITE) begin
            chk("be", bus.proc_be, ebe);
            chk("wdata", bus.proc_wdata, ewd);
        end
        @(negedge CLK);
        bus.proc_gnt = 1'b0;
        if (wr == READ) begin
            repeat (vd) begin
                #1;
                chk("wait_busy", busy, 1);
                chk("wait_req", bus.proc_req, 0);
                @(negedge CLK);
            end
            bus.proc_valid = 1'b1;
            bus.proc_rdata = rd;
            #1;
            chk("valid_busy", busy, 1);
            @(negedge CLK);
            bus.proc_valid = 1'b0;
        end
        #1;
        chk("done_busy", busy, 0);
        chk("done_req", bus.proc_req, 0);
        if (wr == READ) chk("rdata", rdata, erd);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.proc_gnt = 1'b0;
        bus.proc_valid = 1'b0;
        bus.proc_rdata = '0;
        #22;
        chk("rst_req", bus.proc_req, 0);
        chk("rst_we", bus.proc_we, 0);
        chk("rst_addr", bus.proc_addr, 0);
        chk("rst_be", bus.proc_be, 0);
        chk("rst_wdata", bus.proc_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        @(negedge CLK);
        RSTn = 1'b1;

        access(WRITE, LSU_W, 32'h1004, 32'hDEADBEEF, 0, 0, 0, 32'h1004, 4'b1111, 32'hDEADBEEF, 0);
        idle_step();
        access(READ, LSU_B, 32'h2003, 0, 0, 1, 32'h80FF_0000, 32'h2000, 0, 0, 32'hFFFFFF80);
        idle_step();
        access(READ, LSU_HU, 32'h2002, 0, 0, 0, 32'hBEEF_1234, 32'h2000, 0, 0, 32'h0000BEEF);
        idle_step();
        access(WRITE, LSU_H, 32'h2002, 32'h0000ABCD, 0, 0, 0, 32'h2000, 4'b1100, 32'hABCDABCD, 0);
        idle_step();
        access(WRITE, LSU_B, 32'h1001, 32'h0000_0012, 1, 0, 0, 32'h1000, 4'b0010, 32'h12121212, 0);
        idle_step();
        access(READ, LSU_H, 32'h2002, 0, 0, 0, 32'h8001_0000, 32'h2000, 0, 0, 32'hFFFF8001);
        idle_step();
        access(READ, LSU_BU, 32'h2001, 0, 0, 0, 32'h0000_9A00, 32'h2000, 0, 0, 32'h0000009A);
        idle_step();

        // misaligned word, illegal funct3, and EN gating
        @(negedge CLK);
        present(READ, LSU_W, 32'h3001, 0, 1'b1);
        #1;
        chk("mis_err", err, 1);
        chk("mis_busy", busy, 0);
        @(negedge CLK);
        #1;
        chk("mis_req", bus.proc_req, 0);
        f3 = 3'b011;
        addr = 32'h3000;
        #1;
        chk("f3_err", err, 1);
        chk("f3_busy", busy, 0);
        EN = 1'b0;
        #1;
        chk("en_err", err, 0);
        f3 = LSU_W;
        #1;
        chk("en_busy", busy, 0);
        @(negedge CLK);
        #1;
        chk("en_req", bus.proc_req, 0);
        idle_step();

        // grant stalled five cycles, then reset while waiting for read data
        @(negedge CLK);
        present(READ, LSU_W, 32'h2008, 0, 1'b1);
        #1;
        chk("rs_busy", busy, 1);
        repeat (5) begin
            @(negedge CLK);
            #1;
            chk("rs_req", bus.proc_req, 1);
            chk("rs_addr", bus.proc_addr, 32'h2008);
            chk("rs_busy", busy, 1);
        end
        @(negedge CLK);
        bus.proc_gnt = 1'b1;
        @(negedge CLK);
        bus.proc_gnt = 1'b0;
        #1;
        chk("rs_wait_busy", busy, 1);
        RSTn = 1'b0;
        ctl.mem_en = 1'b0;
        #1;
        chk("rs_req_drop", bus.proc_req, 0);
        chk("rs_busy_drop", busy, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        bus.proc_valid = 1'b1;
        bus.proc_rdata = 32'hCAFEBABE;
        @(negedge CLK);
        bus.proc_valid = 1'b0;
        #1;
        chk("rs_rdata", rdata, 0);
        chk("rs_req_after", bus.proc_req, 0);
        chk("rs_busy_after", busy, 0);

        // back-to-back loads, second held off by the hazard unit
        access(READ, LSU_W, 32'h2010, 0, 0, 0, 32'h11111111, 32'h2010, 0, 0, 32'h11111111);
        @(negedge CLK);
        present(READ, LSU_W, 32'h2014, 0, 1'b0);
        #1;
        chk("b2b_hold_busy", busy, 0);
        @(negedge CLK);
        #1;
        chk("b2b_hold_req", bus.proc_req, 0);
        chk("b2b_hold_rdata", rdata, 32'h11111111);
        access(READ, LSU_W, 32'h2014, 0, 0, 0, 32'h22222222, 32'h2014, 0, 0, 32'h22222222);
        idle_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
